// File: rtl/stopwatch_bcd.sv
// Start/stop/lap stopwatch: conditions two raw push buttons, divides CLOCK_50
// into 0.01 s ticks and counts them in a BCD cascade (MM:SS.hh style radix).
module stopwatch_bcd #(
  parameter int unsigned TICK_DIV        = 500000,
  parameter int unsigned N_DIGITS        = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  key_start_n,
  input  logic                  key_lap_n,
  output logic [4*N_DIGITS-1:0] display_bcd,
  output logic                  running,
  output logic                  lap_frozen,
  output logic                  overflow,
  output logic                  tick
);

  localparam int unsigned BCD_W     = 4 * N_DIGITS;
  localparam int unsigned PRESC_W   = $clog2(TICK_DIV);
  localparam int unsigned DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned N_KEYS    = 2;
  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_LAP   = 1;

  // Largest value a digit may hold: tens of seconds / tens of minutes are base 6.
  function automatic logic [3:0] digit_max(input int unsigned idx);
    return (idx[0] && (idx >= 3)) ? 4'd5 : 4'd9;
  endfunction

  // ---------------------------------------------------------------------------
  // Button conditioning (index 0 = start/stop, index 1 = lap/clear)
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] key_raw_n;
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] db_q;
  logic [N_KEYS-1:0] db_prev_q;
  logic [N_KEYS-1:0] press_q;
  logic [DB_W-1:0]   db_cnt_q [N_KEYS];

  assign key_raw_n = {key_lap_n, key_start_n};

  // Synchronise, debounce and turn each accepted press into a one-cycle pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      db_q      <= '1;
      db_prev_q <= '1;
      press_q   <= '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        db_cnt_q[k] <= '0;
      end
    end else begin
      sync1_q   <= key_raw_n;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      press_q   <= db_prev_q & ~db_q;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        if (sync2_q[k] == db_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_q[k]     <= sync2_q[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  logic start_p;
  logic lap_p;

  assign start_p = press_q[KEY_START];
  assign lap_p   = press_q[KEY_LAP];

  // ---------------------------------------------------------------------------
  // Timebase and BCD counter
  // ---------------------------------------------------------------------------
  logic               running_q;
  logic               lap_frozen_q;
  logic               overflow_q;
  logic [PRESC_W-1:0] presc_q;
  logic [BCD_W-1:0]   live_q;
  logic [BCD_W-1:0]   snap_q;

  logic [BCD_W-1:0]   live_inc_c;
  logic               live_wrap_c;
  logic               carry_c;

  assign tick = running_q && (presc_q == PRESC_W'(TICK_DIV - 1));

  // Ripple the tick through the digit cascade; carry out of the top digit is a wrap.
  always_comb begin
    live_inc_c  = live_q;
    live_wrap_c = 1'b0;
    carry_c     = tick;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (carry_c) begin
        if (live_q[4*i +: 4] == digit_max(i)) begin
          live_inc_c[4*i +: 4] = 4'd0;
        end else begin
          live_inc_c[4*i +: 4] = live_q[4*i +: 4] + 4'd1;
          carry_c              = 1'b0;
        end
      end
    end
    live_wrap_c = carry_c;
  end

  // Prescaler, live count and start/lap control; start wins over a coincident lap.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      running_q    <= 1'b0;
      lap_frozen_q <= 1'b0;
      overflow_q   <= 1'b0;
      presc_q      <= '0;
      live_q       <= '0;
      snap_q       <= '0;
    end else begin
      if (running_q) begin
        presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
      end
      live_q <= live_inc_c;
      if (live_wrap_c) begin
        overflow_q <= 1'b1;
      end

      if (start_p) begin
        running_q <= ~running_q;
      end else if (lap_p) begin
        if (lap_frozen_q) begin
          lap_frozen_q <= 1'b0;
        end else if (running_q) begin
          snap_q       <= live_q;
          lap_frozen_q <= 1'b1;
        end else begin
          live_q     <= '0;
          presc_q    <= '0;
          overflow_q <= 1'b0;
        end
      end
    end
  end

  // Display shows the frozen lap snapshot or the live count.
  assign display_bcd = lap_frozen_q ? snap_q : live_q;
  assign running     = running_q;
  assign lap_frozen  = lap_frozen_q;
  assign overflow    = overflow_q;

endmodule
